// File: rtl/cam_capture_pkg.sv
// Shared types and helpers for the camera capture path (cam_capture and its pixel FIFO).
package cam_capture_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, ACTIVE} cap_state_t;

  localparam int PIX_W  = 16;
  localparam int BYTE_W = 8;
  localparam int REC_W  = PIX_W + 2;

  typedef struct packed {
    logic             sof;
    logic             eol;
    logic [PIX_W-1:0] data;
  } pix_rec_t;

  function automatic int col_width(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int row_width(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

endpackage

// File: rtl/cam_pixel_fifo.sv
// First-word-fall-through pixel FIFO; a write into a full FIFO succeeds when a read frees a slot in the same cycle.
module cam_pixel_fifo
  import cam_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [REC_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [REC_W-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = rd_en & ~empty;
  assign do_push = wr_en & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cam_capture.sv
// OV-style parallel camera capture: byte pairs -> RGB565 pixels with sof/eol, buffered as a valid/ready stream.
// Optional 2x2 decimation is built when CAM_CAPTURE_DECIMATE_EN is defined.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_dat,
  input  logic        enable,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] overflow_cnt
);

  localparam int COL_W = col_width(IMG_W);
  localparam int ROW_W = row_width(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  cap_state_t        state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              phase;
  logic              line_full;
  logic              sof_armed;
  logic [BYTE_W-1:0] hi_byte;

  logic [2:0]        pclk_sync;
  logic [2:0]        vsync_sync;
  logic [2:0]        href_sync;
  logic [BYTE_W-1:0] dat_s1;
  logic [BYTE_W-1:0] dat_s2;

  logic pclk_rise, vsync_rise, vsync_fall, href_fall, href_s;
  logic pix_formed, push_req, push_ok, eol_hit, fifo_full, fifo_empty;
  pix_rec_t push_rec;
  pix_rec_t pop_rec;

  // Two flops against metastability, a third stage only for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      dat_s1     <= '0;
      dat_s2     <= '0;
    end else begin
      pclk_sync  <= {pclk_sync[1:0], cam_pclk};
      vsync_sync <= {vsync_sync[1:0], cam_vsync};
      href_sync  <= {href_sync[1:0], cam_href};
      dat_s1     <= cam_dat;
      dat_s2     <= dat_s1;
    end
  end

  assign href_s     = href_sync[1];
  assign pclk_rise  = pclk_sync[1] & ~pclk_sync[2];
  assign vsync_rise = vsync_sync[1] & ~vsync_sync[2];
  assign vsync_fall = ~vsync_sync[1] & vsync_sync[2];
  assign href_fall  = ~href_sync[1] & href_sync[2];

  assign pix_formed = (state == ACTIVE) & ~vsync_rise & pclk_rise & href_s & phase;

`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam logic [COL_W-1:0] COL_EOL = COL_W'(IMG_W - 2);
  assign push_req = pix_formed & ~col[0] & ~row[0];
  assign eol_hit  = (col == COL_EOL) & ~line_full;
`else
  assign push_req = pix_formed;
  assign eol_hit  = (col == COL_LAST) & ~line_full;
`endif

  // A full FIFO still accepts when the consumer pops in the same cycle.
  assign push_ok  = push_req & (~fifo_full | pix_ready);
  assign push_rec = '{sof: sof_armed, eol: eol_hit, data: {hi_byte, dat_s2}};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      phase      <= 1'b0;
      line_full  <= 1'b0;
      sof_armed  <= 1'b0;
      hi_byte    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          if (!enable) begin
            state <= IDLE;
          end else if (vsync_fall) begin
            state     <= ACTIVE;
            busy      <= 1'b1;
            row       <= '0;
            col       <= '0;
            phase     <= 1'b0;
            line_full <= 1'b0;
            sof_armed <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vsync_rise) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= enable ? WAIT_FRAME : IDLE;
          end else if (href_fall) begin
            if (row != ROW_LAST) row <= row + ROW_W'(1);
            col       <= '0;
            phase     <= 1'b0;
            line_full <= 1'b0;
          end else if (pclk_rise && href_s) begin
            if (!phase) begin
              hi_byte <= dat_s2;
              phase   <= 1'b1;
            end else begin
              // Columns past the line end keep counting at the last index without another eol.
              phase <= 1'b0;
              if (col != COL_LAST) col <= col + COL_W'(1);
              else                 line_full <= 1'b1;
              if (push_ok) sof_armed <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_cnt <= '0;
    end else if (push_req && !push_ok && overflow_cnt != 16'hFFFF) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  cam_pixel_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_en  (push_req),
    .wr_data(push_rec),
    .rd_en  (pix_ready),
    .rd_data(pop_rec),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = pop_rec.data;
  assign pix_sof   = pop_rec.sof;
  assign pix_eol   = pop_rec.eol;

endmodule

// File: tb/tb_cam_capture.sv
// Self-checking bench for cam_capture: random camera frames against a line/pixel-level reference model.
module tb_cam_capture;

  localparam int IMG_W      = 4;
`ifdef CAM_CAPTURE_DECIMATE_EN
  localparam int IMG_H      = 4;
`else
  localparam int IMG_H      = 2;
`endif
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_dat = 8'h00;
  logic        enable = 1'b0;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        frame_done;
  logic        busy;
  logic [15:0] overflow_cnt;

  int checks = 0;
  int errors = 0;
  int exp_overflow = 0;
  int fd_cnt = 0;
  int fd_long = 0;
  bit fd_prev = 1'b0;
  bit stall_prev = 1'b0;
  logic [17:0] stall_rec;
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  int line_len[$];

  cam_capture #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cam_pclk    (cam_pclk),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_dat     (cam_dat),
    .enable      (enable),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_eol     (pix_eol),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .frame_done  (frame_done),
    .busy        (busy),
    .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  // Collect transfers, check stall stability and frame_done pulse width.
  always @(negedge clk) begin
    if (resetn) begin
      if (pix_valid && pix_ready) got.push_back({pix_sof, pix_eol, pix_data});
      if (stall_prev) begin
        checks++;
        if (!pix_valid || {pix_sof, pix_eol, pix_data} !== stall_rec) begin
          errors++;
          $display("[TB] FAIL stall_hold: got valid=%0b rec=%h, required valid=1 rec=%h",
                   pix_valid, {pix_sof, pix_eol, pix_data}, stall_rec);
        end
      end
      stall_prev = pix_valid && !pix_ready;
      stall_rec  = {pix_sof, pix_eol, pix_data};
      if (frame_done) fd_cnt++;
      if (frame_done && fd_prev) fd_long++;
      fd_prev = frame_done;
    end else begin
      stall_prev = 1'b0;
      fd_prev    = 1'b0;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_dat = b;
    wait_clk(4);
    cam_pclk = 1'b1;
    wait_clk(4);
    cam_pclk = 1'b0;
  endtask

  // Sends one frame from line_len[]; the model turns each line's bytes into expected pixels.
  task automatic send_frame(input bit ramp, input bit hold_low, input int drop_en_line,
                            input bit expect_capture);
    logic [17:0] cand[$];
    logic [7:0]  bytes[$];
    logic [7:0]  ramp_val;
    logic [7:0]  b;
    bit          keep;
    bit          eol;
    bit          sof_armed;
    int          row;
    int          kept;
    ramp_val  = 8'h12;
    pix_ready = !hold_low;
    cam_vsync = 1'b0;
    wait_clk(8);
    for (int l = 0; l < line_len.size(); l++) begin
      bytes.delete();
      for (int i = 0; i < line_len[l]; i++) begin
        b = ramp ? ramp_val : 8'($urandom);
        ramp_val = ramp_val + 8'h22;
        bytes.push_back(b);
      end
      cam_href = 1'b1;
      foreach (bytes[i]) send_byte(bytes[i]);
      cam_href = 1'b0;
      wait_clk(6);
      row = (l < IMG_H) ? l : IMG_H - 1;
      for (int k = 0; k < line_len[l] / 2; k++) begin
`ifdef CAM_CAPTURE_DECIMATE_EN
        keep = (k < IMG_W) && (k % 2 == 0) && (row % 2 == 0);
        eol  = (k == IMG_W - 2);
`else
        keep = 1'b1;
        eol  = (k == IMG_W - 1);
`endif
        if (keep) cand.push_back({1'b0, eol, bytes[2*k], bytes[2*k+1]});
      end
      if (l == drop_en_line) enable = 1'b0;
    end
    cam_vsync = 1'b1;
    wait_clk(12);
    if (expect_capture) begin
      sof_armed = 1'b1;
      kept = 0;
      foreach (cand[i]) begin
        if (!hold_low || kept < FIFO_DEPTH) begin
          exp_q.push_back({sof_armed, cand[i][16:0]});
          sof_armed = 1'b0;
          kept++;
        end else begin
          exp_overflow++;
        end
      end
    end
  endtask

  task automatic drain_compare(input string name, input bit rand_ready);
    int n;
    for (int c = 0; c < 600 && got.size() < exp_q.size(); c++) begin
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      wait_clk(1);
    end
    pix_ready = 1'b1;
    wait_clk(4);
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d pixels, required %0d", name, got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s_pix%0d: got sof/eol/data %h, required %h", name, i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_empty: got pix_valid %b, required 0", name, pix_valid);
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    wait_clk(3);
    checks += 7;
    if (pix_valid !== 1'b0)     begin errors++; $display("[TB] FAIL rst_valid: got %b, required 0", pix_valid); end
    if (pix_data !== 16'h0)     begin errors++; $display("[TB] FAIL rst_data: got %h, required 0", pix_data); end
    if (pix_sof !== 1'b0)       begin errors++; $display("[TB] FAIL rst_sof: got %b, required 0", pix_sof); end
    if (pix_eol !== 1'b0)       begin errors++; $display("[TB] FAIL rst_eol: got %b, required 0", pix_eol); end
    if (frame_done !== 1'b0)    begin errors++; $display("[TB] FAIL rst_fd: got %b, required 0", frame_done); end
    if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
    if (overflow_cnt !== 16'h0) begin errors++; $display("[TB] FAIL rst_ovf: got %h, required 0", overflow_cnt); end
    resetn = 1'b1;
    enable = 1'b1;
    wait_clk(20);
  endtask

  task automatic test_basic_frame();
    int fd0;
    fd0 = fd_cnt;
    line_len = '{8, 8};
    send_frame(1'b1, 1'b0, -1, 1'b1);
    checks += 2;
    if (fd_cnt - fd0 != 1) begin errors++; $display("[TB] FAIL basic_fd_count: got %0d, required 1", fd_cnt - fd0); end
    if (fd_long != 0)      begin errors++; $display("[TB] FAIL basic_fd_width: got %0d long pulses, required 0", fd_long); end
`ifndef CAM_CAPTURE_DECIMATE_EN
    checks++;
    if (got.size() < 8) begin
      errors++;
      $display("[TB] FAIL basic_early_count: got %0d, required 8", got.size());
    end else begin
      checks += 2;
      if (got[0] !== 18'h21234) begin errors++; $display("[TB] FAIL basic_first: got %h, required 21234", got[0]); end
      if (got[3][16] !== 1'b1 || got[7][16] !== 1'b1 || got[2][16] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL basic_eol: got eol p3=%b p4=%b p8=%b, required 0 1 1", got[2][16], got[3][16], got[7][16]);
      end
    end
`endif
    drain_compare("basic", 1'b0);
  endtask

  task automatic test_overflow();
    line_len = '{8, 8};
    send_frame(1'b0, 1'b1, -1, 1'b1);
    checks++;
    if (overflow_cnt !== 16'(exp_overflow)) begin
      errors++;
      $display("[TB] FAIL ovf_cnt: got %0d, required %0d", overflow_cnt, exp_overflow);
    end
    drain_compare("overflow", 1'b1);
  endtask

  task automatic test_odd_lines();
    line_len = '{3, 8};
    send_frame(1'b0, 1'b0, -1, 1'b1);
    drain_compare("dangling", 1'b0);
    line_len = '{10, 6};
    send_frame(1'b0, 1'b0, -1, 1'b1);
    drain_compare("long_line", 1'b1);
  endtask

  task automatic test_random_frames();
    bit hold;
    for (int f = 0; f < 5; f++) begin
      line_len.delete();
      for (int l = 0; l < $urandom_range(1, 4); l++) line_len.push_back($urandom_range(1, 11));
      hold = 1'($urandom_range(0, 1));
      send_frame(1'b0, hold, -1, 1'b1);
      checks++;
      if (overflow_cnt !== 16'(exp_overflow)) begin
        errors++;
        $display("[TB] FAIL rand%0d_ovf: got %0d, required %0d", f, overflow_cnt, exp_overflow);
      end
      drain_compare("random", 1'b1);
    end
  endtask

  task automatic test_reset_midline();
    cam_vsync = 1'b0;
    wait_clk(8);
    cam_href = 1'b1;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    resetn = 1'b0;
    #2;
    checks += 3;
    if (pix_valid !== 1'b0)     begin errors++; $display("[TB] FAIL midrst_valid: got %b, required 0", pix_valid); end
    if (busy !== 1'b0)          begin errors++; $display("[TB] FAIL midrst_busy: got %b, required 0", busy); end
    if (overflow_cnt !== 16'h0) begin errors++; $display("[TB] FAIL midrst_ovf: got %h, required 0", overflow_cnt); end
    exp_overflow = 0;
    wait_clk(3);
    resetn = 1'b1;
    wait_clk(2);
    got.delete();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    cam_href = 1'b0;
    wait_clk(6);
    cam_href = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'($urandom));
    cam_href = 1'b0;
    wait_clk(6);
    cam_vsync = 1'b1;
    wait_clk(12);
    checks += 2;
    if (got.size() != 0)     begin errors++; $display("[TB] FAIL partial_frame: got %0d pixels, required 0", got.size()); end
    if (pix_valid !== 1'b0)  begin errors++; $display("[TB] FAIL partial_valid: got %b, required 0", pix_valid); end
    line_len = '{8, 8};
    send_frame(1'b0, 1'b0, -1, 1'b1);
    drain_compare("after_reset", 1'b0);
  endtask

  task automatic test_enable_clear();
    int fd0;
    fd0 = fd_cnt;
    line_len = '{8, 8};
    send_frame(1'b0, 1'b0, 0, 1'b1);
    checks += 2;
    if (fd_cnt - fd0 != 1) begin errors++; $display("[TB] FAIL en_fd: got %0d pulses, required 1", fd_cnt - fd0); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL en_busy: got %b, required 0", busy); end
    drain_compare("enable_clear", 1'b0);
    send_frame(1'b0, 1'b0, -1, 1'b0);
    checks += 2;
    if (got.size() != 0)   begin errors++; $display("[TB] FAIL disabled_frame: got %0d pixels, required 0", got.size()); end
    if (fd_cnt - fd0 != 1) begin errors++; $display("[TB] FAIL disabled_fd: got %0d pulses, required 1", fd_cnt - fd0); end
    got.delete();
    enable = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    $display("[TB] cam_capture bench start");
    test_reset();
    test_basic_frame();
    test_overflow();
    test_odd_lines();
    test_random_frames();
    test_reset_midline();
    test_enable_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
